// File: rtl/aorb_result_display_if.sv
// Bus between the AorB operand stage / host and the result display stage.
// master drives result/load; slave (the display stage) drives the status and display pins.
interface aorb_result_display_if;
  logic [5:0] result;
  logic       load;
  logic       busy;
  logic       done;
  logic [7:0] bcd;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (output result, load, input busy, done, bcd, seg, an);
  modport slave  (input result, load, output busy, done, bcd, seg, an);
endinterface

// File: rtl/aorb_result_display.sv
// Captures a 6-bit result, converts it to two BCD digits by double-dabble and drives a
// multiplexed active-low 2-digit 7-segment display. Define AORB_DISP_LZB_EN for tens-digit blanking.
module aorb_result_display #(
  parameter int REFRESH_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  aorb_result_display_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CYCLES - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] s;
    case (digit)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dabble_adj(input logic [3:0] nib);
    logic [3:0] r;
    if (nib >= 4'd5) begin
      r = nib + 4'd3;
    end else begin
      r = nib;
    end
    return r;
  endfunction

  state_t        state_q, state_d;
  logic [5:0]    sr_q, sr_d;
  logic [7:0]    scr_q, scr_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    bcd_q, bcd_d;
  logic          done_q, done_d;
  logic [RW-1:0] ref_q, ref_d;
  logic          dsel_q, dsel_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic [7:0]    scr_adj_s;
  logic [13:0]   shifted_s;

  // Conversion FSM: next state, shift datapath and latch of the finished BCD value.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    scr_d     = scr_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    done_d    = 1'b0;
    scr_adj_s = {dabble_adj(scr_q[7:4]), dabble_adj(scr_q[3:0])};
    shifted_s = {scr_adj_s, sr_q} << 1;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          sr_d    = bus.result;
          scr_d   = 8'h00;
          cnt_d   = 3'd0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        scr_d = shifted_s[13:6];
        sr_d  = shifted_s[5:0];
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd5) begin
          state_d = LATCH;
        end else begin
          state_d = SHIFT;
        end
      end
      LATCH: begin
        bcd_d   = scr_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Refresh timer and display multiplexer; always shows the last latched value.
  always_comb begin
    ref_d  = ref_q + RW'(1);
    dsel_d = dsel_q;
    if (ref_q == REF_LAST) begin
      ref_d  = '0;
      dsel_d = ~dsel_q;
    end else begin
      dsel_d = dsel_q;
    end
    if (dsel_q) begin
      an_d = 2'b01;
`ifdef AORB_DISP_LZB_EN
      if (bcd_q[7:4] == 4'd0) begin
        seg_d = 7'h7F;
      end else begin
        seg_d = seg_decode(bcd_q[7:4]);
      end
`else
      seg_d = seg_decode(bcd_q[7:4]);
`endif
    end else begin
      an_d  = 2'b10;
      seg_d = seg_decode(bcd_q[3:0]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= 6'd0;
      scr_q   <= 8'h00;
      cnt_q   <= 3'd0;
      bcd_q   <= 8'h00;
      done_q  <= 1'b0;
      ref_q   <= '0;
      dsel_q  <= 1'b0;
      seg_q   <= 7'h7F;
      an_q    <= 2'b11;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      done_q  <= done_d;
      ref_q   <= ref_d;
      dsel_q  <= dsel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;
  assign bus.seg  = seg_q;
  assign bus.an   = an_q;

endmodule

// File: tb/tb_aorb_result_display.sv
// Scoreboard bench for aorb_result_display: stimulus pushes expected bcd/done cycle, a
// negedge monitor pops and compares on each done pulse.
module tb_aorb_result_display;

  localparam int R = 4;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;
  int   done_cnt;

  typedef struct {
    logic [7:0] bcd;
    int         due;
  } exp_t;

  exp_t sb[$];

  aorb_result_display_if bus_if ();

  aorb_result_display #(.REFRESH_CYCLES(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

`ifdef AORB_DISP_LZB_EN
  localparam logic [6:0] TENS_ZERO = 7'h7F;
`else
  localparam logic [6:0] TENS_ZERO = 7'h40;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus_if.done === 1'b1) begin
      exp_t e;
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done: got done=1 bcd=%0h expected no done (cycle %0d)", bus_if.bcd, cyc);
      end else begin
        e = sb.pop_front();
        if (bus_if.bcd !== e.bcd || cyc != e.due) begin
          failures++;
          $display("FAIL done_bcd: got bcd=%0h at cycle %0d expected bcd=%0h at cycle %0d",
                   bus_if.bcd, cyc, e.bcd, e.due);
        end
      end
    end
  end

  task automatic issue(input logic [5:0] v, input logic [7:0] exp_bcd);
    bus_if.result = v;
    bus_if.load   = 1'b1;
    sb.push_back('{bcd: exp_bcd, due: cyc + 8});
    @(posedge clk); #1;
    bus_if.load   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_disp(input string name, input logic [6:0] tens, input logic [6:0] ones);
    int n;
    repeat (2) @(negedge clk);
    n = 0;
    while (bus_if.an !== 2'b01 && n < 3 * R) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_tens"}, {25'd0, bus_if.seg}, {25'd0, tens});
    n = 0;
    while (bus_if.an !== 2'b10 && n < 3 * R) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ones"}, {25'd0, bus_if.seg}, {25'd0, ones});
    @(posedge clk); #1;
  endtask

  initial begin
    int busy_n;
    cyc           = 0;
    checks        = 0;
    failures      = 0;
    done_cnt      = 0;
    rst           = 1'b1;
    bus_if.result = 6'd0;
    bus_if.load   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_done", {31'd0, bus_if.done}, 32'd0);
    chk("rst_bcd",  {24'd0, bus_if.bcd},  32'h00);
    chk("rst_seg",  {25'd0, bus_if.seg},  32'h7F);
    chk("rst_an",   {30'd0, bus_if.an},   32'd3);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 2 * R; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("refresh_an", {30'd0, bus_if.an}, (i < R) ? 32'd2 : 32'd1);
      chk("refresh_seg", {25'd0, bus_if.seg}, (i < R) ? 32'h40 : {25'd0, TENS_ZERO});
    end
    @(posedge clk); #1;

    // 63: busy for 7 cycles, done 7 clocks after load
    issue(6'd63, 8'h63);
    busy_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.busy === 1'b1) busy_n++;
    end
    chk("busy_cycles", busy_n, 32'd8);
    drain();
    check_disp("disp63", 7'h02, 7'h30);

    issue(6'd0, 8'h00);
    drain();
    check_disp("disp00", TENS_ZERO, 7'h40);
    issue(6'd9, 8'h09);
    drain();
    check_disp("disp09", TENS_ZERO, 7'h10);

    // 10 with loads of 55 at cycles 3 and 7 after the first load
    done_cnt = 0;
    bus_if.result = 6'd10;
    bus_if.load   = 1'b1;
    sb.push_back('{bcd: 8'h10, due: cyc + 8});
    @(posedge clk); #1;
    bus_if.load = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus_if.result = 6'd55; bus_if.load = 1'b1;
    @(posedge clk); #1;
    bus_if.load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus_if.load = 1'b1;
    @(posedge clk); #1;
    bus_if.load = 1'b0;
    drain();
    repeat (12) @(posedge clk);
    #1;
    chk("drop_done_count", done_cnt, 32'd1);
    check_disp("disp10", 7'h79, 7'h40);

    // Back-to-back sweep with load held high
    for (int v = 0; v < 64; v++) begin
      bus_if.result = 6'(v);
      bus_if.load   = 1'b1;
      sb.push_back('{bcd: {4'(v / 10), 4'(v % 10)}, due: cyc + 8});
      repeat (8) @(posedge clk);
      #1;
    end
    bus_if.load = 1'b0;
    drain();

    // Reset 4 cycles into a conversion of 47
    bus_if.result = 6'd47;
    bus_if.load   = 1'b1;
    @(posedge clk); #1;
    bus_if.load = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("abort_done", {31'd0, bus_if.done}, 32'd0);
    chk("abort_bcd",  {24'd0, bus_if.bcd},  32'h00);
    chk("abort_seg",  {25'd0, bus_if.seg},  32'h7F);
    chk("abort_an",   {30'd0, bus_if.an},   32'd3);
    @(posedge clk); #1;
    rst = 1'b0;
    done_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_done", done_cnt, 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
